dezigzag_dequant_block: RTL

Decoder-side counterpart of the block compression path. It accepts one 8x8 block of quantized DCT coefficients as a serial stream in zigzag order, as an entropy decoder emits them. Each coefficient is multiplied by its quantization-table entry and written to its raster position in an 8x8 output array. When the block is complete, it pulses block_done so the downstream inverse-DCT stage can consume the array.

---
 rtl/decoder_pkg.sv | 30 +++
 rtl/dezigzag_dequant_block.sv | 96 +++++++++
 2 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared decoder constants: block geometry, zigzag order, block FSM states
//
// Purpose: single definition of the 8x8 zigzag scan order used by both the
// encoder-side zigzag writer and the decoder-side de-zigzag/dequant block.
// Ports: none (package).

package decoder_pkg;

  localparam int BLOCK_DIM  = 8;
  localparam int NUM_COEFFS = BLOCK_DIM * BLOCK_DIM;

  // ZIGZAG[i] is the raster index (row*8+col) of the i-th coefficient in scan order.
  localparam logic [5:0] ZIGZAG [NUM_COEFFS] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

endpackage

// File: rtl/dezigzag_dequant_block.sv
// rtl/dezigzag_dequant_block.sv - de-zigzag and dequantize one 8x8 coefficient block
//
// Purpose: accepts 64 quantized coefficients in zigzag order, multiplies each by
// the quant-table entry latched at block start, and writes the product to its
// raster position. block_done pulses for one cycle once all 64 entries are final.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start_block     - begin a new block (IDLE only); latches qtable
//   qtable          - unsigned quant table [row][col]
//   in_valid/in_ready/in_coeff - zigzag-ordered coefficient stream
//   dequant_coeffs  - registered dequantized block [row][col]
//   block_done      - one-cycle completion pulse

module dezigzag_dequant_block
  import decoder_pkg::*;
#(
  parameter int COEFF_W = 16,
  parameter int Q_W     = 8,
  parameter int OUT_W   = COEFF_W + Q_W
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start_block,
  input  logic        [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q_W-1:0] qtable,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic signed [COEFF_W-1:0]                           in_coeff,
  output logic signed [BLOCK_DIM-1:0][BLOCK_DIM-1:0][OUT_W-1:0] dequant_coeffs,
  output logic                                                block_done
);

  state_t state, next_state;
  logic [5:0] idx;
  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][Q_W-1:0] q_latched;

  logic              accept;
  logic [5:0]        pos;
  logic [2:0]        row, col;
  logic signed [OUT_W-1:0] coeff_ext, q_ext, product;

  assign accept = in_valid && in_ready;
  assign pos    = ZIGZAG[idx];
  assign row    = pos[5:3];
  assign col    = pos[2:0];

  // Sign-extend the coefficient and zero-extend the table entry so a plain
  // signed multiply at OUT_W gives the exact signed x unsigned product.
  assign coeff_ext = {{(OUT_W-COEFF_W){in_coeff[COEFF_W-1]}}, in_coeff};
  assign q_ext     = {{(OUT_W-Q_W){1'b0}}, q_latched[row][col]};
  assign product   = coeff_ext * q_ext;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    block_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_block) next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept && idx == 6'(NUM_COEFFS - 1)) next_state = DONE;
      end
      DONE: begin
        block_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output array is not cleared at block start: it holds the previous block
  // until each entry is overwritten by the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      q_latched      <= '0;
      dequant_coeffs <= '0;
    end else begin
      if (state == IDLE && start_block) begin
        q_latched <= qtable;
        idx       <= '0;
      end
      if (accept) begin
        dequant_coeffs[row][col] <= product;
        idx                      <= idx + 6'd1;
      end
    end
  end

endmodule
